// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA transmit and receive paths: FSM state
// encoding, parity-select codes, data-width offset and small decode helpers.
package acia_pkg;

    // Transmit FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // cfg_par codes; 2'b11 also means no parity.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // cfg_bits encodes the data width minus this offset.
    localparam int unsigned DATA_BITS_OFS = 5;

    // Index of the last data bit of a frame for a given cfg_bits code.
    function automatic logic [2:0] last_data_idx(input logic [1:0] bits);
        return 3'(DATA_BITS_OFS - 1) + 3'(bits);
    endfunction

    // True when the parity code asks for a parity bit.
    function automatic logic par_enabled(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

endpackage

// File: rtl/acia_fifo.sv
// Synchronous FIFO shared by the ACIA transmit and receive sides.
// Show-ahead read: dout presents the head entry while empty=0.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset (empties the FIFO)
//   push, din     write strobe and data; ignored while full
//   pop, dout     read strobe and head data; ignored while empty
//   full, empty   occupancy flags decoded from the level register
//   level         number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module acia_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/acia_tx2.sv
// ACIA transmitter: byte FIFO feeding an async-serial framer
// (start, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits).
// Build option: define ACIA_TX2_PARITY_EN to include the parity bit logic;
// without it cfg_par is ignored and frames never carry a parity bit.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   pclk          bit-timing enable; the framer advances only when high
//   tx_dat, tx_wr byte and enqueue strobe (evaluated every clk)
//   cfg_div       bit period minus one, in pclk ticks
//   cfg_bits      data bits minus 5
//   cfg_par       00/11 none, 01 even, 10 odd
//   cfg_stop      0: one stop bit, 1: two
//   tx_serial     serial line, idle high
//   tx_busy       FIFO non-empty or frame in progress
//   tx_full       FIFO full
//   tx_level      FIFO occupancy
//   tx_ovf        sticky dropped-write flag, cleared only by reset
module acia_tx2
    import acia_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pclk,
    input  logic [7:0]                    tx_dat,
    input  logic                          tx_wr,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_bits,
    input  logic [1:0]                    cfg_par,
    input  logic                          cfg_stop,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_ovf
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       bits_q, bits_d;
    logic             stop_q, stop_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic             serial_d;
    logic             busy_d;
    logic             ovf_d;
    logic             load_frame;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;

`ifdef ACIA_TX2_PARITY_EN
    logic [1:0]       par_q, par_d;
    logic             par_acc_q, par_acc_d;
`else
    logic             unused_cfg_par;
    assign unused_cfg_par = ^cfg_par;
`endif

    // tx_full is the start-of-cycle flag, so a write into a full FIFO is
    // dropped even when the framer pops in the same cycle.
    assign fifo_push = tx_wr && !tx_full;

    acia_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (tx_dat),
        .dout    (fifo_dout),
        .full    (tx_full),
        .empty   (fifo_empty),
        .level   (tx_level)
    );

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bits_d     = bits_q;
        stop_d     = stop_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        serial_d   = tx_serial;
        fifo_pop   = 1'b0;
        load_frame = 1'b0;
        ovf_d      = tx_ovf || (tx_wr && tx_full);
`ifdef ACIA_TX2_PARITY_EN
        par_d      = par_q;
        par_acc_d  = par_acc_q;
`endif

        if (pclk) begin
            if (state_q == IDLE) begin
                load_frame = !fifo_empty;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - DIV_W'(1);
            end else begin
                // Bit boundary: reload the period and move to the next bit.
                cnt_d = div_q;
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        serial_d  = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_idx_d = '0;
`ifdef ACIA_TX2_PARITY_EN
                        par_acc_d = shreg_q[0];
`endif
                    end
                    DATA: begin
                        if (bit_idx_q == last_data_idx(bits_q)) begin
                            state_d    = STOP;
                            serial_d   = 1'b1;
                            stop_idx_d = 1'b0;
`ifdef ACIA_TX2_PARITY_EN
                            if (par_enabled(par_q)) begin
                                state_d  = PARITY;
                                serial_d = par_acc_q ^ (par_q == PAR_ODD);
                            end
`endif
                        end else begin
                            serial_d  = shreg_q[0];
                            shreg_d   = {1'b0, shreg_q[7:1]};
                            bit_idx_d = bit_idx_q + 3'd1;
`ifdef ACIA_TX2_PARITY_EN
                            par_acc_d = par_acc_q ^ shreg_q[0];
`endif
                        end
                    end
`ifdef ACIA_TX2_PARITY_EN
                    PARITY: begin
                        state_d    = STOP;
                        serial_d   = 1'b1;
                        stop_idx_d = 1'b0;
                    end
`endif
                    STOP: begin
                        if (stop_q && !stop_idx_q) begin
                            stop_idx_d = 1'b1;
                        end else if (!fifo_empty) begin
                            load_frame = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            serial_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d  = IDLE;
                        serial_d = 1'b1;
                    end
                endcase
            end

            // Pop a byte and freeze the configuration for the whole frame.
            if (load_frame) begin
                fifo_pop = 1'b1;
                state_d  = START;
                serial_d = 1'b0;
                cnt_d    = cfg_div;
                div_d    = cfg_div;
                bits_d   = cfg_bits;
                stop_d   = cfg_stop;
                shreg_d  = fifo_dout;
`ifdef ACIA_TX2_PARITY_EN
                par_d    = cfg_par;
`endif
            end
        end

        // Busy when a frame continues or the FIFO still holds data after this edge.
        busy_d = (state_d != IDLE) || fifo_push || (tx_level > LVL_W'(fifo_pop));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bits_q     <= '0;
            stop_q     <= 1'b0;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            tx_ovf     <= 1'b0;
`ifdef ACIA_TX2_PARITY_EN
            par_q      <= PAR_NONE;
            par_acc_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bits_q     <= bits_d;
            stop_q     <= stop_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_serial  <= serial_d;
            tx_busy    <= busy_d;
            tx_ovf     <= ovf_d;
`ifdef ACIA_TX2_PARITY_EN
            par_q      <= par_d;
            par_acc_q  <= par_acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_acia_tx2.sv
// Testbench for acia_tx2 (FIFO_DEPTH=4): hand-computed frame table, directed
// corner-case sequences and a randomized run, all checked against a
// tick-level reference model of the serial line and FIFO.
module tb_acia_tx2;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

`ifdef ACIA_TX2_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             pclk = 1'b0;
    logic [7:0]       tx_dat = '0;
    logic             tx_wr = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [1:0]       cfg_bits = 2'b11;
    logic [1:0]       cfg_par = 2'b00;
    logic             cfg_stop = 1'b0;
    logic             tx_serial;
    logic             tx_busy;
    logic             tx_full;
    logic [LVL_W-1:0] tx_level;
    logic             tx_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acia_tx2 #(
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pclk      (pclk),
        .tx_dat    (tx_dat),
        .tx_wr     (tx_wr),
        .cfg_div   (cfg_div),
        .cfg_bits  (cfg_bits),
        .cfg_par   (cfg_par),
        .cfg_stop  (cfg_stop),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_full   (tx_full),
        .tx_level  (tx_level),
        .tx_ovf    (tx_ovf)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Byte queue plus a queue of line levels, one entry per pclk tick of the
    // frame being sent. A frame starts when the tick queue has run dry.
    logic [7:0] mq[$];
    bit         tq[$];
    bit         m_valid  = 1'b0;
    bit         m_active = 1'b0;
    bit         m_ovf    = 1'b0;
    bit         m_ser    = 1'b1;
    bit         m_full_s;
    bit         m_empty_s;

    function automatic void build_frame(input logic [7:0] d);
        int nb;
        bit p;
        bit seq[$];
        nb = 5 + int'(cfg_bits);
        p  = 1'b0;
        seq.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            seq.push_back(d[i]);
            p = p ^ d[i];
        end
        if (PEN && cfg_par == 2'b01) seq.push_back(p);
        if (PEN && cfg_par == 2'b10) seq.push_back(!p);
        seq.push_back(1'b1);
        if (cfg_stop) seq.push_back(1'b1);
        foreach (seq[k])
            for (int r = 0; r <= int'(cfg_div); r++) tq.push_back(seq[k]);
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            tq.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
            m_ser    = 1'b1;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            m_full_s  = (mq.size() == DEPTH);
            m_empty_s = (mq.size() == 0);
            if (tx_wr && m_full_s) m_ovf = 1'b1;
            if (pclk) begin
                if (tq.size() == 0 && !m_empty_s) build_frame(mq.pop_front());
                if (tq.size() != 0) begin
                    m_ser    = tq.pop_front();
                    m_active = 1'b1;
                end else begin
                    m_ser    = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (tx_wr && !m_full_s) mq.push_back(tx_dat);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_serial", 32'(tx_serial), 32'(m_ser));
            check("m_busy",   32'(tx_busy),   32'(m_active || mq.size() != 0));
            check("m_level",  32'(tx_level),  32'(mq.size()));
            check("m_full",   32'(tx_full),   32'(mq.size() == DEPTH));
            check("m_ovf",    32'(tx_ovf),    32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tx_wr   = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int k;
        k = 0;
        while (tx_busy && k < max_cyc) begin
            tick();
            k++;
        end
        check(name, 32'(tx_busy), 32'd0);
    endtask

    // Samples one frame starting at the pop edge; per = clk cycles per bit.
    // In slow mode pclk pulses one cycle in four and cfg_bits is changed mid-frame.
    task automatic capture_frame(input string name, input int n, input int per,
                                 input logic [11:0] exp, input bit slow);
        logic [11:0] got;
        bit          stable;
        got    = '0;
        stable = 1'b1;
        for (int c = 0; c < n * per; c++) begin
            if (slow) begin
                pclk = (c % 4 == 0);
                if (c == 8) cfg_bits = 2'b00;
            end
            tick();
            if (c % per == 0) got[c / per] = tx_serial;
            else if (tx_serial !== got[c / per]) stable = 1'b0;
        end
        check({name, "_bits"}, 32'(got), 32'(exp));
        check({name, "_hold"}, 32'(stable), 32'd1);
        if (slow) pclk = 1'b1;
        tick();
        check({name, "_busy_end"}, 32'(tx_busy), 32'd0);
        check({name, "_idle"}, 32'(tx_serial), 32'd1);
    endtask

    typedef struct {
        logic [7:0]       dat;
        logic [1:0]       bits;
        logic [1:0]       par;
        logic             stop;
        logic [DIV_W-1:0] div;
        int               n;
        logic [11:0]      seq;   // bit i = i-th bit on the line
    } vec_t;

    vec_t vt[6];

    bit s[66];
    bit allb;
    int wr_mod;

    initial begin
        vt[0] = '{8'hA5, 2'd3, 2'b00, 1'b0, 16'd3, 10, 12'h34A};
        vt[1] = '{8'h03, 2'd2, 2'b01, 1'b0, 16'd1, PEN ? 10 : 9,  PEN ? 12'h206 : 12'h106};
        vt[2] = '{8'h03, 2'd2, 2'b10, 1'b0, 16'd1, PEN ? 10 : 9,  PEN ? 12'h306 : 12'h106};
        vt[3] = '{8'hFF, 2'd0, 2'b11, 1'b1, 16'd0, 8, 12'h0FE};
        vt[4] = '{8'h80, 2'd1, 2'b01, 1'b1, 16'd2, PEN ? 10 : 9,  PEN ? 12'h300 : 12'h180};
        vt[5] = '{8'h5A, 2'd3, 2'b10, 1'b0, 16'd0, PEN ? 11 : 10, PEN ? 12'h6B4 : 12'h2B4};

        // Reset state.
        tick();
        reset_n = 1'b1;
        check("rst_serial", 32'(tx_serial), 32'd1);
        check("rst_busy",   32'(tx_busy),   32'd0);
        check("rst_full",   32'(tx_full),   32'd0);
        check("rst_level",  32'(tx_level),  32'd0);
        check("rst_ovf",    32'(tx_ovf),    32'd0);

        // Frame table.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            cfg_div  = vt[v].div;
            cfg_bits = vt[v].bits;
            cfg_par  = vt[v].par;
            cfg_stop = vt[v].stop;
            pclk     = 1'b1;
            tx_dat   = vt[v].dat;
            tx_wr    = 1'b1;
            tick();
            tx_wr    = 1'b0;
            capture_frame($sformatf("vec%0d", v), vt[v].n, int'(vt[v].div) + 1, vt[v].seq, 1'b0);
        end

        // FIFO fill with pclk held low: 4th write fills, 5th is dropped.
        do_reset();
        pclk = 1'b0; cfg_div = '0; cfg_bits = 2'd3; cfg_par = 2'b00; cfg_stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_dat = 8'(8'h10 + i);
            tx_wr  = 1'b1;
            tick();
            if (i == 2) check("fill_full3", 32'(tx_full), 32'd0);
            if (i == 3) check("fill_full4", 32'(tx_full), 32'd1);
        end
        tx_wr = 1'b0;
        check("fill_level", 32'(tx_level), 32'd4);
        check("fill_ovf",   32'(tx_ovf),   32'd1);
        pclk = 1'b1;
        wait_idle("fill_drain", 200);
        check("ovf_sticky", 32'(tx_ovf), 32'd1);

        // Write into a full FIFO on the same edge as a pop is still dropped.
        do_reset();
        pclk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_dat = 8'(8'h20 + i);
            tx_wr  = 1'b1;
            tick();
        end
        pclk   = 1'b1;
        tx_dat = 8'hEE;
        tick();
        tx_wr  = 1'b0;
        check("popwr_level", 32'(tx_level), 32'd3);
        check("popwr_ovf",   32'(tx_ovf),   32'd1);
        wait_idle("popwr_drain", 300);

        // Three back-to-back frames with two stop bits, cfg_div=1.
        do_reset();
        pclk = 1'b1; cfg_div = 16'd1; cfg_bits = 2'd3; cfg_par = 2'b00; cfg_stop = 1'b1;
        tx_dat = 8'h11; tx_wr = 1'b1;
        tick();
        allb = 1'b1;
        for (int c = 0; c < 66; c++) begin
            if (c == 0) tx_dat = 8'h22;
            if (c == 1) tx_dat = 8'h33;
            if (c == 2) tx_wr  = 1'b0;
            tick();
            s[c] = tx_serial;
            if (!tx_busy) allb = 1'b0;
        end
        check("b2b_stop1", 32'({s[17], s[18], s[19], s[20], s[21], s[22]}), 32'(6'b011110));
        check("b2b_stop2", 32'({s[39], s[40], s[41], s[42], s[43], s[44]}), 32'(6'b011110));
        check("b2b_busy",  32'(allb), 32'd1);
        tick();
        check("b2b_end", 32'(tx_busy), 32'd0);

        // Reset in the middle of a data bit.
        do_reset();
        pclk = 1'b0; cfg_div = 16'd3; cfg_bits = 2'd3; cfg_par = 2'b00; cfg_stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_dat = 8'(8'h40 + i);
            tx_wr  = 1'b1;
            tick();
        end
        tx_wr = 1'b0;
        pclk  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("mid_pre_level", 32'(tx_level), 32'd3);
        check("mid_pre_ovf",   32'(tx_ovf),   32'd1);
        reset_n = 1'b0;
        tick();
        check("mid_serial", 32'(tx_serial), 32'd1);
        check("mid_busy",   32'(tx_busy),   32'd0);
        check("mid_level",  32'(tx_level),  32'd0);
        check("mid_ovf",    32'(tx_ovf),    32'd0);
        check("mid_full",   32'(tx_full),   32'd0);
        reset_n = 1'b1;

        // pclk one cycle in four, cfg_div=0, cfg_bits changed mid-frame.
        do_reset();
        pclk = 1'b0; cfg_div = '0; cfg_bits = 2'd3; cfg_par = 2'b00; cfg_stop = 1'b0;
        tx_dat = 8'hA5; tx_wr = 1'b1;
        tick();
        tx_wr = 1'b0;
        capture_frame("slow", 10, 4, 12'h34A, 1'b1);

        // Randomized traffic, configuration churn and occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) wr_mod = (c / 500) % 3 == 0 ? 2 : ((c / 500) % 3 == 1 ? 8 : 30);
            pclk   = ($urandom_range(0, 3) != 0);
            tx_wr  = ($urandom_range(0, wr_mod - 1) == 0);
            tx_dat = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                cfg_div  = DIV_W'($urandom_range(0, 2));
                cfg_bits = 2'($urandom);
                cfg_par  = 2'($urandom);
                cfg_stop = 1'($urandom);
            end
            reset_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        reset_n = 1'b1;
        tx_wr   = 1'b0;
        pclk    = 1'b1;
        wait_idle("rand_drain", 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
